// File: rtl/axi_mem_if_pkg.sv
// Shared definitions for the AXI memory interface blocks.
// Holds the pointer-width helper used by the channel buffers.
package axi_mem_if_pkg;

  // Pointer width for an n-entry store; never narrower than one bit.
  function automatic int unsigned buf_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axi_buffer_wrap_cnt.sv
// Modulo-N counter with enable and synchronous clear.
// Wraps from N-1 to 0 by compare, so N need not be a power of two.
module axi_buffer_wrap_cnt
  import axi_mem_if_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = buf_width(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= (cnt_o == LAST) ? '0 : cnt_o + ONE;
    end
  end

endmodule

// File: rtl/axi_buffer_flex.sv
// Elastic AXI channel buffer: any depth, optional fall-through,
// synchronous flush and fill-level reporting.
module axi_buffer_flex
  import axi_mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 4,
  parameter bit          FALL_THROUGH     = 1'b0,
  parameter int unsigned AFULL_THRESH     = BUFFER_DEPTH - 1,
  parameter int unsigned LOG_BUFFER_DEPTH = buf_width(BUFFER_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  input  logic                      ready_i,
  output logic [LOG_BUFFER_DEPTH:0] usage_o,
  output logic                      almost_full_o
);

  localparam int unsigned UW = LOG_BUFFER_DEPTH + 1;
  localparam logic [UW-1:0] FULL_CNT = UW'(BUFFER_DEPTH);
  localparam logic [UW-1:0] AF_CNT   = UW'(AFULL_THRESH);
  localparam logic [UW-1:0] ONE      = UW'(1);

  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
  logic [UW-1:0]               usage;
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
  logic live;
  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;
  logic store;
  logic drain;

  assign live   = rst_ni & ~flush_i;
  assign empty  = (usage == '0);
  assign full   = (usage == FULL_CNT);
  assign bypass = FALL_THROUGH & empty & valid_i;

  assign ready_o = ~full & live;
  assign valid_o = live & (~empty | bypass);

  always_comb begin
    data_o = '0;
    if (valid_o) begin
      data_o = bypass ? data_i : mem[rd_ptr];
    end
  end

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  // A bypassed beat that is taken never touches the store.
  assign store = push & ~(bypass & ready_i);
  assign drain = pop & ~bypass;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      usage <= '0;
    end else if (flush_i) begin
      usage <= '0;
    end else if (store & ~drain) begin
      usage <= usage + ONE;
    end else if (drain & ~store) begin
      usage <= usage - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem[wr_ptr] <= data_i;
    end
  end

  axi_buffer_wrap_cnt #(
    .N (BUFFER_DEPTH),
    .W (LOG_BUFFER_DEPTH)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .en_i   (store),
    .cnt_o  (wr_ptr)
  );

  axi_buffer_wrap_cnt #(
    .N (BUFFER_DEPTH),
    .W (LOG_BUFFER_DEPTH)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .en_i   (drain),
    .cnt_o  (rd_ptr)
  );

  assign usage_o       = usage;
  assign almost_full_o = (usage >= AF_CNT);

endmodule

// File: tb/tb_axi_buffer_flex.sv
// Directed bench for axi_buffer_flex across four configurations:
// depth 3 registered, depth 3 fall-through, depth 4 and depth 1.
module tb_axi_buffer_flex;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // a: depth 3, registered, almost-full at 2
  logic a_valid, a_ready, a_valid_o, a_ready_i, a_af;
  logic [15:0] a_data, a_data_o;
  logic [2:0] a_usage;
  // b: depth 3, fall-through
  logic b_valid, b_ready, b_valid_o, b_ready_i, b_af;
  logic [15:0] b_data, b_data_o;
  logic [2:0] b_usage;
  // c: depth 4, registered, almost-full at 3
  logic c_valid, c_ready, c_valid_o, c_ready_i, c_af;
  logic [15:0] c_data, c_data_o;
  logic [2:0] c_usage;
  // d: depth 1, registered
  logic d_valid, d_ready, d_valid_o, d_ready_i, d_af;
  logic [15:0] d_data, d_data_o;
  logic [1:0] d_usage;

  axi_buffer_flex #(.DATA_WIDTH(16), .BUFFER_DEPTH(3), .FALL_THROUGH(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(a_valid),
    .data_i(a_data), .ready_o(a_ready), .valid_o(a_valid_o), .data_o(a_data_o),
    .ready_i(a_ready_i), .usage_o(a_usage), .almost_full_o(a_af));

  axi_buffer_flex #(.DATA_WIDTH(16), .BUFFER_DEPTH(3), .FALL_THROUGH(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(b_valid),
    .data_i(b_data), .ready_o(b_ready), .valid_o(b_valid_o), .data_o(b_data_o),
    .ready_i(b_ready_i), .usage_o(b_usage), .almost_full_o(b_af));

  axi_buffer_flex #(.DATA_WIDTH(16), .BUFFER_DEPTH(4), .FALL_THROUGH(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(c_valid),
    .data_i(c_data), .ready_o(c_ready), .valid_o(c_valid_o), .data_o(c_data_o),
    .ready_i(c_ready_i), .usage_o(c_usage), .almost_full_o(c_af));

  axi_buffer_flex #(.DATA_WIDTH(16), .BUFFER_DEPTH(1), .FALL_THROUGH(1'b0),
                    .AFULL_THRESH(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(d_valid),
    .data_i(d_data), .ready_o(d_ready), .valid_o(d_valid_o), .data_o(d_data_o),
    .ready_i(d_ready_i), .usage_o(d_usage), .almost_full_o(d_af));

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    a_valid = 1'b1; a_data = 16'h1234; a_ready_i = 1'b1;
    b_valid = 1'b1; b_data = 16'h5678; b_ready_i = 1'b1;
    c_valid = 1'b0; c_data = '0; c_ready_i = 1'b0;
    d_valid = 1'b0; d_data = '0; d_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({a_ready, a_valid_o, a_data_o, a_usage, a_af} !== 22'd0) begin
      bad++;
      $display("FAIL reset_a: got rdy=%b vld=%b data=%h use=%0d af=%b want all 0",
               a_ready, a_valid_o, a_data_o, a_usage, a_af);
    end
    total++;
    if ({b_ready, b_valid_o, b_data_o} !== 18'd0) begin
      bad++;
      $display("FAIL reset_b_bypass: got rdy=%b vld=%b data=%h want 0 0 0",
               b_ready, b_valid_o, b_data_o);
    end
    a_valid = 1'b0; a_ready_i = 1'b0;
    b_valid = 1'b0; b_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b1 || a_usage !== 3'd0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b use=%0d want 1 0", a_ready, a_usage);
    end
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    logic [15:0] v [3];
    v[0] = 16'h00A1; v[1] = 16'h00B2; v[2] = 16'h00C3;
    a_ready_i = 1'b0;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = v[i];
      @(negedge clk);
      total++;
      if (a_usage !== 3'(i + 1) || a_af !== (i + 1 >= 2)) begin
        bad++;
        $display("FAIL fill_usage[%0d]: got use=%0d af=%b want %0d %b",
                 i, a_usage, a_af, i + 1, (i + 1 >= 2));
      end
    end
    a_valid = 1'b0;
    #1;
    total++;
    if (a_ready !== 1'b0 || a_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL fill_full: got rdy=%b vld=%b want 0 1", a_ready, a_valid_o);
    end
    a_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (a_valid_o !== 1'b1 || a_data_o !== v[i]) begin
        bad++;
        $display("FAIL drain_order[%0d]: got vld=%b data=%h want 1 %h",
                 i, a_valid_o, a_data_o, v[i]);
      end
      @(negedge clk);
    end
    a_ready_i = 1'b0;
    #1;
    total++;
    if (a_usage !== 3'd0 || a_valid_o !== 1'b0 || a_data_o !== 16'h0) begin
      bad++;
      $display("FAIL drain_empty: got use=%0d vld=%b data=%h want 0 0 0",
               a_usage, a_valid_o, a_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    errs = 0;
    a_valid = 1'b1;
    a_data = 16'd100;
    @(negedge clk);
    a_ready_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      a_data = 16'(100 + k);
      #1;
      if (a_data_o !== 16'(100 + k - 1) || a_ready !== 1'b1) errs++;
      @(negedge clk);
      if (a_usage !== 3'd1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL b2b_stream: got %0d order/usage errors want 0", errs);
    end
    a_valid = 1'b0;
    #1;
    total++;
    if (a_data_o !== 16'd110) begin
      bad++;
      $display("FAIL b2b_last: got %0d want 110", a_data_o);
    end
    @(negedge clk);
    a_ready_i = 1'b0;
    total++;
    if (a_usage !== 3'd0) begin
      bad++;
      $display("FAIL b2b_drained: got use=%0d want 0", a_usage);
    end
  endtask

  task automatic test_fall_through();
    b_valid = 1'b1;
    b_data = 16'hCAFE;
    b_ready_i = 1'b1;
    #1;
    total++;
    if (b_valid_o !== 1'b1 || b_data_o !== 16'hCAFE) begin
      bad++;
      $display("FAIL ft_bypass: got vld=%b data=%h want 1 cafe", b_valid_o, b_data_o);
    end
    @(negedge clk);
    total++;
    if (b_usage !== 3'd0) begin
      bad++;
      $display("FAIL ft_bypass_usage: got %0d want 0", b_usage);
    end
    b_ready_i = 1'b0;
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    total++;
    if (b_usage !== 3'd1 || b_valid_o !== 1'b1 || b_data_o !== 16'hCAFE) begin
      bad++;
      $display("FAIL ft_store: got use=%0d vld=%b data=%h want 1 1 cafe",
               b_usage, b_valid_o, b_data_o);
    end
    b_valid = 1'b1;
    b_data = 16'hBEEF;
    b_ready_i = 1'b1;
    #1;
    total++;
    if (b_data_o !== 16'hCAFE) begin
      bad++;
      $display("FAIL ft_order: got %h want cafe", b_data_o);
    end
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    total++;
    if (b_usage !== 3'd1 || b_data_o !== 16'hBEEF) begin
      bad++;
      $display("FAIL ft_second: got use=%0d data=%h want 1 beef", b_usage, b_data_o);
    end
    @(negedge clk);
    b_ready_i = 1'b0;
    total++;
    if (b_usage !== 3'd0 || b_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL ft_empty: got use=%0d vld=%b want 0 0", b_usage, b_valid_o);
    end
  endtask

  task automatic test_flush();
    c_ready_i = 1'b0;
    c_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      c_data = 16'(i);
      @(negedge clk);
    end
    total++;
    if (c_usage !== 3'd3 || c_af !== 1'b1) begin
      bad++;
      $display("FAIL flush_prefill: got use=%0d af=%b want 3 1", c_usage, c_af);
    end
    flush = 1'b1;
    c_data = 16'h0009;
    c_ready_i = 1'b1;
    #1;
    total++;
    if (c_ready !== 1'b0 || c_valid_o !== 1'b0 || c_data_o !== 16'h0) begin
      bad++;
      $display("FAIL flush_during: got rdy=%b vld=%b data=%h want 0 0 0",
               c_ready, c_valid_o, c_data_o);
    end
    @(negedge clk);
    flush = 1'b0;
    c_valid = 1'b0;
    c_ready_i = 1'b0;
    #1;
    total++;
    if (c_usage !== 3'd0 || c_valid_o !== 1'b0 || c_af !== 1'b0) begin
      bad++;
      $display("FAIL flush_after: got use=%0d vld=%b af=%b want 0 0 0",
               c_usage, c_valid_o, c_af);
    end
    c_valid = 1'b1;
    c_data = 16'h0007;
    @(negedge clk);
    c_valid = 1'b0;
    #1;
    total++;
    if (c_usage !== 3'd1 || c_data_o !== 16'h0007) begin
      bad++;
      $display("FAIL flush_refill: got use=%0d data=%h want 1 0007", c_usage, c_data_o);
    end
    c_ready_i = 1'b1;
    @(negedge clk);
    c_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    c_valid = 1'b1;
    c_data = 16'h0011;
    @(negedge clk);
    c_data = 16'h0022;
    @(negedge clk);
    total++;
    if (c_usage !== 3'd2) begin
      bad++;
      $display("FAIL rst_mid_prefill: got use=%0d want 2", c_usage);
    end
    rst_n = 1'b0;
    c_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (c_valid_o !== 1'b0 || c_ready !== 1'b0 || c_data_o !== 16'h0) begin
        bad++;
        $display("FAIL rst_mid_hold[%0d]: got vld=%b rdy=%b data=%h want 0 0 0",
                 i, c_valid_o, c_ready, c_data_o);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    c_valid = 1'b0;
    c_ready_i = 1'b0;
    #1;
    total++;
    if (c_usage !== 3'd0 || c_ready !== 1'b1 || c_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_release: got use=%0d rdy=%b vld=%b want 0 1 0",
               c_usage, c_ready, c_valid_o);
    end
  endtask

  task automatic test_depth1();
    logic [15:0] q[$];
    int pushes, pops, cycles, errs, toggles;
    logic last_rdy;
    pushes = 0; pops = 0; cycles = 0; errs = 0; toggles = 0;
    last_rdy = d_ready;
    while (pushes < 100 && cycles < 2000) begin
      d_valid = 1'($urandom_range(0, 1));
      d_data = 16'($urandom);
      d_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (d_ready !== (q.size() == 0)) errs++;
      if (d_usage !== 2'(q.size())) errs++;
      if (d_valid_o !== (q.size() != 0)) errs++;
      if (d_ready !== last_rdy) toggles++;
      last_rdy = d_ready;
      if (d_valid_o && d_ready_i) begin
        if (q.size() == 0 || d_data_o !== q[0]) errs++;
        if (q.size() != 0) void'(q.pop_front());
        pops++;
      end
      if (d_valid && d_ready) begin
        q.push_back(d_data);
        pushes++;
      end
      @(negedge clk);
      cycles++;
    end
    d_valid = 1'b0;
    d_ready_i = 1'b1;
    #1;
    if (q.size() != 0) begin
      if (d_data_o !== q[0]) errs++;
      void'(q.pop_front());
      pops++;
    end
    @(negedge clk);
    d_ready_i = 1'b0;
    total++;
    if (cycles >= 2000) begin
      bad++;
      $display("FAIL d1_timeout: got %0d pushes want 100", pushes);
    end
    total++;
    if (errs != 0 || pops != pushes) begin
      bad++;
      $display("FAIL d1_stream: got errs=%0d pops=%0d want 0 %0d", errs, pops, pushes);
    end
    total++;
    if (toggles < 2 || d_usage !== 2'd0) begin
      bad++;
      $display("FAIL d1_ready_toggle: got toggles=%0d use=%0d want >=2 0",
               toggles, d_usage);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_fall_through();
    test_flush();
    test_reset_mid();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_buffer_flex.md
# axi_buffer_flex

Parametrised elastic buffer for AXI channel payloads (AW/AR/W/R/B), the next generation of the plain two-entry channel buffer. It adds arbitrary depth (including non-power-of-two), optional fall-through (zero-latency bypass when empty), a synchronous flush, and fill-level reporting (occupancy and almost-full) for upstream throttling. It sits between an AXI master-side port and the slave-side port of the memory interface, one instance per channel.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1)
- BUFFER_DEPTH, 4, number of storage entries (≥1, any integer)
- FALL_THROUGH, 0, 1 = empty-buffer bypass with zero latency; 0 = registered output, 1-cycle latency
- AFULL_THRESH, BUFFER_DEPTH-1, occupancy at or above which almost_full_o asserts (1..BUFFER_DEPTH)
- LOG_BUFFER_DEPTH, max(1, clog2(BUFFER_DEPTH)), derived pointer width; not overridden
- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  discard all stored entries
- valid_i  in  1  input payload valid
- data_i  in  DATA_WIDTH  input payload
- ready_o  out  1  buffer accepts payload
- valid_o  out  1  output payload valid
- data_o  out  DATA_WIDTH  output payload
- ready_i  in  1  downstream accepts payload
- usage_o  out  LOG_BUFFER_DEPTH+1  number of stored entries (0..BUFFER_DEPTH)
- almost_full_o  out  1  usage_o ≥ AFULL_THRESH

## Operation
- push = valid_i & ready_o; pop = valid_o & ready_i.
- ready_o = !full & !flush_i & rst_ni; full = (usage == BUFFER_DEPTH). No combinational path ready_i → ready_o.
- Buffered path: push writes data_i to mem[wr_ptr], wr_ptr advances; pop advances rd_ptr; data_o = mem[rd_ptr] when usage ≠ 0.
- Pointers wrap from BUFFER_DEPTH-1 to 0 (explicit compare, not power-of-two masking).
- usage: +1 on push only, −1 on pop only, unchanged on both or neither; push and pop in the same cycle are legal at any occupancy except push when full.
- FALL_THROUGH=1, usage==0, valid_i=1: valid_o=1, data_o=data_i combinationally. If ready_i=1, payload passes through: no memory write, pointers and usage unchanged. If ready_i=0, payload is stored normally (usage→1).
- FALL_THROUGH=0: valid_o = (usage ≠ 0); never depends on valid_i in the same cycle.
- valid_o forced 0 while flush_i=1 or rst_ni=0; data_o driven 0 whenever valid_o=0.
- flush_i=1 at an edge: usage, wr_ptr, rd_ptr ← 0; no handshake occurs in that cycle (ready_o=valid_o=0). Memory contents not cleared.
- Reset (rst_ni=0 at edge): usage, wr_ptr, rd_ptr ← 0. Memory not reset. Reset has priority over flush.
- almost_full_o = (usage ≥ AFULL_THRESH), combinational from the usage register; usage_o reports stored entries only (bypassed payloads never counted).

## Timing
- Reset values/while rst_ni=0: ready_o=0, valid_o=0, data_o=0, usage_o=0, almost_full_o=0 (AFULL_THRESH ≥1). First cycle after reset released: ready_o=1.
- Latency FALL_THROUGH=0: payload pushed at edge N is on data_o with valid_o=1 in cycle after N.
- Latency FALL_THROUGH=1: 0 cycles when empty; otherwise as above (FIFO order preserved — bypass only when usage==0).
- Throughput: one push and one pop per cycle sustained at any occupancy 1..BUFFER_DEPTH-1; at full, a pop frees a slot usable from the next cycle.
- Reset or flush mid-burst: stored entries lost, no partial handshake; upstream must re-send.

## Structure
- Shared package axi_mem_if_pkg: clog2-style width function replacing the ad-hoc log2 macro, used for LOG_BUFFER_DEPTH.
- One sub-module natural: axi_buffer_wrap_cnt (parametrised modulo-N counter with enable and synchronous clear), instanced for wr_ptr and rd_ptr.
- Storage as a plain register array; usage counter and output muxing in the top module.

## Test plan
- DEPTH=3, FALL_THROUGH=0: push A,B,C with ready_i=0 → usage_o 1,2,3, ready_o=0 after C, almost_full_o=1 at usage 2; then ready_i=1 → A,B,C out in order, one per cycle.
- DEPTH=3: 10 simultaneous push/pop cycles at usage 1 → usage_o stays 1, rd/wr pointers wrap past 2→0, output order matches input.
- FALL_THROUGH=1, empty, valid_i=1 data 0xCAFE, ready_i=1 → valid_o=1, data_o=0xCAFE same cycle, usage_o stays 0; with ready_i=0 → usage_o=1 next cycle, 0xCAFE presented.
- DEPTH=4 holding 3 entries, flush_i=1 with valid_i=1 → ready_o=valid_o=0 that cycle, next cycle usage_o=0, valid_o=0, pushed payload not stored.
- rst_ni=0 held 2 cycles mid-traffic at usage 2 → valid_o=ready_o=0, data_o=0 during reset; after release usage_o=0, ready_o=1.
- DEPTH=1: alternate push/pop → full after one push, ready_o toggles, no data loss or duplication over 100 random transactions.
